// File: rtl/piezo_pkg.sv
//------------------------------------------------------------------------------
// piezo_pkg : shared types and constants for the piezo buzzer scheduler
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package piezo_pkg;

    localparam int C_TIMER_W         = 27;
    localparam int C_TIMEOUT_CYC_SIM = 2**23;
    localparam int C_TIMEOUT_CYC_HW  = 2**27;
    localparam int C_GAP_CYC_SIM     = 64;
    localparam int C_GAP_CYC_HW      = 1024;

    typedef enum logic [1:0] {
        CHIRP   = 2'd0,
        FANFARE = 2'd1,
        ERROR   = 2'd2
    } tune_id_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_PLAY   = 2'd2,
        S_GAP    = 2'd3
    } sched_state_t;

    // Strict priority: error over fanfare over chirp.
    function automatic tune_id_t prio_pick(input logic [2:0] pend);
        if (pend[2]) begin
            return ERROR;
        end else if (pend[1]) begin
            return FANFARE;
        end
        return CHIRP;
    endfunction

    function automatic logic [2:0] tune_onehot(input tune_id_t id);
        return 3'b001 << id;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
//------------------------------------------------------------------------------
// cycle_timer : loadable down-counter that saturates at zero
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cycle_timer
    import piezo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [C_TIMER_W-1:0] load_val,
    input  logic                 en,
    output logic                 zero
);

    logic [C_TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - C_TIMER_W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/piezo_sched.sv
//------------------------------------------------------------------------------
// piezo_sched : priority arbiter and sequencer for the shared piezo buzzer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piezo_sched
    import piezo_pkg::*;
#(
    parameter int FAST_SIM    = 1,
    parameter int TIMEOUT_CYC = (FAST_SIM != 0) ? C_TIMEOUT_CYC_SIM : C_TIMEOUT_CYC_HW,
    parameter int GAP_CYC     = (FAST_SIM != 0) ? C_GAP_CYC_SIM : C_GAP_CYC_HW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       mute,
    input  logic [2:0] tune_piezo,
    input  logic [2:0] tune_done,
    output logic [2:0] go,
    output logic       piezo,
    output logic       piezo_n,
    output logic       busy,
    output logic       timeout
);

    localparam logic [C_TIMER_W-1:0] C_TIMEOUT_LOAD = C_TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [C_TIMER_W-1:0] C_GAP_LOAD     = C_TIMER_W'(GAP_CYC - 1);

    sched_state_t         state_q, state_d;
    tune_id_t             sel_q, sel_d;
    logic [2:0]           pending_q, pending_d;
    logic [2:0]           pend_clr;
    logic [2:0]           go_q, go_d;
    logic                 timeout_q, timeout_d;
    logic                 piezo_q, piezo_d;
    logic                 piezo_n_q, piezo_n_d;
    logic                 busy_q, busy_d;
    logic                 tmr_load;
    logic [C_TIMER_W-1:0] tmr_val;
    logic                 tmr_en;
    logic                 tmr_zero;
    logic                 done_sel;
    logic                 drive_ok;

    cycle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign done_sel = tune_done[sel_q];
    assign drive_ok = (state_q == S_PLAY) && !mute;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        pend_clr  = '0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        go_d      = '0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d = S_LAUNCH;
                    sel_d   = prio_pick(pending_q);
                    go_d    = tune_onehot(prio_pick(pending_q));
                end
            end
            S_LAUNCH: begin
                pend_clr = tune_onehot(sel_q);
                tmr_load = 1'b1;
                tmr_val  = C_TIMEOUT_LOAD;
                state_d  = S_PLAY;
            end
            S_PLAY: begin
                // A completion in the same cycle as expiry is a normal finish.
                if (done_sel) begin
                    state_d  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = C_GAP_LOAD;
                end else if (tmr_zero) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = C_GAP_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_zero) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // New requests override the launch-time clear so nothing is lost.
        pending_d = (pending_q & ~pend_clr) | (req & {3{~mute}});
        piezo_d   = tune_piezo[sel_q] & drive_ok;
        piezo_n_d = ~tune_piezo[sel_q] & drive_ok;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= CHIRP;
            pending_q <= '0;
            go_q      <= '0;
            timeout_q <= 1'b0;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
            go_q      <= go_d;
            timeout_q <= timeout_d;
            piezo_q   <= piezo_d;
            piezo_n_q <= piezo_n_d;
            busy_q    <= busy_d;
        end
    end

    assign go      = go_q;
    assign timeout = timeout_q;
    assign piezo   = piezo_q;
    assign piezo_n = piezo_n_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_piezo_sched.sv
//------------------------------------------------------------------------------
// tb_piezo_sched : scoreboard bench for piezo_sched against a timeline model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_piezo_sched;

    localparam int T = 300;
    localparam int G = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mute = 1'b0;
    logic [2:0] req = '0;
    logic [2:0] tune_piezo = '0;
    logic [2:0] tune_done = '0;
    logic [2:0] go;
    logic       piezo, piezo_n, busy, timeout;

    always #5 clk = ~clk;

    piezo_sched #(
        .FAST_SIM    (1),
        .TIMEOUT_CYC (T),
        .GAP_CYC     (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mute       (mute),
        .tune_piezo (tune_piezo),
        .tune_done  (tune_done),
        .go         (go),
        .piezo      (piezo),
        .piezo_n    (piezo_n),
        .busy       (busy),
        .timeout    (timeout)
    );

    typedef struct {int cyc; logic [2:0] val;} ev_t;
    typedef struct {int cyc; logic p; logic pn; logic b;} pin_t;

    ev_t  go_exp[$];
    int   to_exp[$];
    pin_t pin_exp[$];
    int   len_plan[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;

    // Timeline model: a tune is described by its launch cycle, its end cycle
    // and the fixed gap; the scheduler is idle once end+1+G has been reached.
    bit [2:0] m_pend   = '0;
    bit       m_active = 0;
    int       m_id, m_g, m_end, m_done_at;

    function automatic int pick_len();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return -1;
        if (r == 1) return T;
        return $urandom_range(1, 60);
    endfunction

    task automatic step(input logic [2:0] r, input bit rs);
        logic [2:0] tp, td;
        bit play_now;
        int t, len;
        t = cyc;
        if (m_active && m_end >= 0 && t >= m_end + 1 + G) m_active = 0;
        tp = 3'($urandom);
        td = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
        if (m_active) td[m_id] = 1'b0;
        play_now = m_active && (t > m_g) && (m_end < 0);
        if (play_now && t == m_done_at) td[m_id] = 1'b1;
        req        = r;
        rst_n      = ~rs;
        tune_piezo = tp;
        tune_done  = td;
        if (rs) begin
            m_pend   = '0;
            m_active = 0;
            pin_exp.push_back('{t + 1, 1'b0, 1'b0, 1'b0});
        end else begin
            if (!m_active && m_pend != 0) begin
                m_id      = m_pend[2] ? 2 : (m_pend[1] ? 1 : 0);
                m_active  = 1;
                m_g       = t + 1;
                m_end     = -1;
                len       = (len_plan.size() != 0) ? len_plan.pop_front() : pick_len();
                m_done_at = (len < 0) ? -1 : m_g + len;
                go_exp.push_back('{t + 1, 3'(1 << m_id)});
            end
            if (play_now) begin
                if (td[m_id]) begin
                    m_end = t;
                end else if (t == m_g + T) begin
                    m_end = t;
                    to_exp.push_back(t + 1);
                end
            end
            pin_exp.push_back('{t + 1,
                                play_now & ~mute & tp[m_id],
                                play_now & ~mute & ~tp[m_id],
                                m_active && !(m_end >= 0 && t + 1 >= m_end + 1 + G)});
            if (m_active && t == m_g) m_pend[m_id] = 1'b0;
            m_pend = m_pend | (r & {3{~mute}});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        pin_t pe;
        ev_t  ge;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pin_exp.size() != 0 && pin_exp[0].cyc == cyc) begin
                    pe = pin_exp.pop_front();
                    checks++;
                    if ({piezo, piezo_n, busy} !== {pe.p, pe.pn, pe.b}) begin
                        errors++;
                        $display("FAIL pins cyc=%0d piezo/piezo_n/busy got %b%b%b exp %b%b%b",
                                 cyc, piezo, piezo_n, busy, pe.p, pe.pn, pe.b);
                    end
                end
                while (go_exp.size() != 0 && go_exp[0].cyc < cyc) begin
                    ge = go_exp.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL go_missing cyc=%0d got none exp %b", ge.cyc, ge.val);
                end
                if (go !== 3'b000) begin
                    checks++;
                    if (go_exp.size() != 0 && go_exp[0].cyc == cyc) begin
                        ge = go_exp.pop_front();
                        if (go !== ge.val) begin
                            errors++;
                            $display("FAIL go_value cyc=%0d got %b exp %b", cyc, go, ge.val);
                        end
                    end else begin
                        errors++;
                        $display("FAIL go_unexpected cyc=%0d got %b exp 000", cyc, go);
                    end
                end
                while (to_exp.size() != 0 && to_exp[0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_missing cyc=%0d got 0 exp 1", to_exp.pop_front());
                end
                if (timeout !== 1'b0) begin
                    checks++;
                    if (to_exp.size() != 0 && to_exp[0] == cyc) begin
                        void'(to_exp.pop_front());
                    end else begin
                        errors++;
                        $display("FAIL timeout_unexpected cyc=%0d got %b exp 0", cyc, timeout);
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(3'b000, 1'b1);
        mon_en = 1;
        step(3'b000, 1'b1);
        idle_run(3);

        // Single chirp: go two cycles after the request, done 100 after it.
        len_plan.push_back(98);
        step(3'b001, 1'b0);
        idle_run(100 + G + 10);

        // Simultaneous requests resolve error, fanfare, chirp.
        len_plan.push_back(20);
        len_plan.push_back(30);
        len_plan.push_back(40);
        step(3'b111, 1'b0);
        idle_run(3 * G + 120);

        // Error arriving mid-fanfare waits its turn.
        len_plan.push_back(50);
        len_plan.push_back(10);
        step(3'b010, 1'b0);
        idle_run(10);
        step(3'b100, 1'b0);
        idle_run(2 * G + 80);

        // Watchdog on a fanfare that never finishes.
        len_plan.push_back(-1);
        step(3'b010, 1'b0);
        idle_run(T + G + 20);

        // Done coinciding with watchdog expiry.
        len_plan.push_back(T);
        step(3'b001, 1'b0);
        idle_run(T + G + 20);

        // Mute during play, then requests while muted.
        len_plan.push_back(60);
        step(3'b001, 1'b0);
        idle_run(20);
        mute = 1'b1;
        idle_run(10);
        mute = 1'b0;
        idle_run(60 + G);
        mute = 1'b1;
        step(3'b111, 1'b0);
        step(3'b010, 1'b0);
        idle_run(5);
        mute = 1'b0;
        idle_run(30);

        // Reset mid-play with an error request pending.
        len_plan.push_back(100);
        step(3'b010, 1'b0);
        idle_run(10);
        step(3'b100, 1'b0);
        idle_run(5);
        step(3'b000, 1'b1);
        idle_run(40);

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            logic [2:0] r;
            r = '0;
            for (int b = 0; b < 3; b++) r[b] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) mute = ~mute;
            step(r, ($urandom_range(0, 1999) == 0));
        end
        mute = 1'b0;
        idle_run(T + 2 * G + 20);

        checks++;
        if (go_exp.size() != 0 || to_exp.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got go=%0d timeout=%0d pending exp 0",
                     go_exp.size(), to_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
